match_alu_pipe: RTL
===================

Name: match_alu_pipe

Overview:
- Registered, parametrised successor to the combinational selector-dispatch ALU.
- Decodes a selector against parameterised match constants and computes the selected arithmetic result on operands A/B.
- Adds a valid/ready handshake, a one-deep output register with backpressure, a persistent accumulator mode, and a registered HIT flag.
- Sits between an operand producer and a result consumer in the datapath; standard PyXHDL-generated SystemVerilog.

Parameters:
- NBITS, 8, operand, accumulator and result width.
- SBITS, 8, selector width.
- K_INC, 17, selector value for XOUT = A + 1.
- K_ADD, 21, selector value for XOUT = A + B.
- K_SUB, 34, selector value for XOUT = A - B.
- K_ACC, 51, selector value for ACC = ACC + A*B, with XOUT = new ACC.
- K_CLR, 68, selector value for XOUT = old ACC, then ACC = 0.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  operand beat valid.
- IN_READY  out  1  block can accept a beat.
- SEL  in  SBITS  operation selector.
- A  in  NBITS  operand A, unsigned.
- B  in  NBITS  operand B, unsigned.
- OUT_VALID  out  1  XOUT/HIT hold a result.
- OUT_READY  in  1  consumer accepts the result.
- XOUT  out  NBITS  result.
- HIT  out  1  1 = SEL matched a K_* constant; 0 = default path taken.

Behaviour:
- Reset (RST=1 at a clock edge):
  - OUT_VALID=0, XOUT=0, HIT=0, ACC=0.
  - Any result pending at the output is discarded.
  - RST has priority over every other event in the same cycle.
- Handshake:
  - IN_READY = !OUT_VALID || OUT_READY (combinational).
  - Accept occurs when IN_VALID && IN_READY at a clock edge.
  - Output transfer occurs when OUT_VALID && OUT_READY.
- Latency: 1 cycle. A beat accepted at edge N is visible on XOUT/HIT with OUT_VALID=1 after edge N.
- Throughput: one beat per cycle while OUT_READY=1.
- Edge update rules:
  - Accept occurs: load XOUT and HIT, set OUT_VALID=1. This covers a simultaneous output transfer and accept.
  - Output transfer only (no accept): clear OUT_VALID; XOUT and HIT hold their values.
  - Neither occurs: XOUT, HIT and OUT_VALID hold, so XOUT is stable under backpressure.
- Dispatch:
  - Priority order when K values collide: K_INC > K_ADD > K_SUB > K_ACC > K_CLR.
  - HIT=1 on any match.
  - Default path (no match): XOUT = low NBITS of A*B, HIT=0.
- Width rules:
  - All results are truncated modulo 2^NBITS.
  - A+1 wraps: 255 + 1 = 0 at NBITS=8.
  - A-B is a two's-complement wrap.
  - The product is computed at 2*NBITS and then truncated.
- ACC behaviour:
  - ACC changes only on an accepted K_ACC or K_CLR beat; non-accepted cycles never touch it.
  - K_ACC: ACC_next = (ACC + A*B) mod 2^NBITS, and XOUT = ACC_next.
  - K_CLR: XOUT = ACC before clearing, and ACC_next = 0. A and B are ignored.
- Selector independence: inputs are sampled only on accept. Changes to SEL/A/B while IN_READY=0 have no effect.

Test Plan:
- Reset, then SEL=17 A=255 B=x; next SEL=17 A=5, with OUT_READY=1 -> XOUT=0 HIT=1, then XOUT=6 HIT=1, one cycle after each accept.
- SEL=21 A=200 B=100 -> XOUT=44 HIT=1; then SEL=34 A=3 B=5 -> XOUT=254 HIT=1; then SEL=0 A=20 B=20 -> XOUT=144 HIT=0.
- SEL=68 (clear); SEL=51 A=3 B=4 -> XOUT=12; SEL=51 A=10 B=30 -> XOUT=56; SEL=68 -> XOUT=56; SEL=51 A=1 B=1 -> XOUT=1.
- Backpressure:
  - Setup: accept SEL=21 A=1 B=2, then hold OUT_READY=0 for 3 cycles with IN_VALID=1 SEL=51 A=9 B=9.
  - Required during the stall: IN_READY=0, XOUT=3 stable, OUT_VALID=1, ACC unchanged.
  - On OUT_READY=1: the SEL=51 beat is accepted in the same cycle.
- Streaming: IN_VALID=1 and OUT_READY=1 every cycle with SEL=21, A=i, B=i for i=0..9 -> ten consecutive results 2*i, with no bubbles.
- Reset mid-operation:
  - Setup: ACC=56 and OUT_VALID=1; assert RST for one cycle together with IN_VALID=1 SEL=51.
  - Required: OUT_VALID=0, XOUT=0, HIT=0, ACC=0 (beat dropped).
  - Next, SEL=68 returns XOUT=0.

Source files
------------

// File: rtl/match_alu_pipe.sv
// Registered selector-dispatch ALU: decodes SEL against match constants, computes on A/B,
// and presents the result through a one-deep valid/ready output register with an accumulator.
module match_alu_pipe #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned SBITS = 8,
  parameter int unsigned K_INC = 17,
  parameter int unsigned K_ADD = 21,
  parameter int unsigned K_SUB = 34,
  parameter int unsigned K_ACC = 51,
  parameter int unsigned K_CLR = 68
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [SBITS-1:0] SEL,
  input  logic [NBITS-1:0] A,
  input  logic [NBITS-1:0] B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [NBITS-1:0] XOUT,
  output logic             HIT
);

  localparam logic [SBITS-1:0] SelInc = SBITS'(K_INC);
  localparam logic [SBITS-1:0] SelAdd = SBITS'(K_ADD);
  localparam logic [SBITS-1:0] SelSub = SBITS'(K_SUB);
  localparam logic [SBITS-1:0] SelAcc = SBITS'(K_ACC);
  localparam logic [SBITS-1:0] SelClr = SBITS'(K_CLR);

  logic             out_valid_q;
  logic [NBITS-1:0] xout_q, xout_d;
  logic             hit_q, hit_d;
  logic [NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0] prod;
  logic             accept;
  logic             transfer;

  assign IN_READY  = !out_valid_q || OUT_READY;
  assign accept    = IN_VALID && IN_READY;
  assign transfer  = out_valid_q && OUT_READY;
  assign OUT_VALID = out_valid_q;
  assign XOUT      = xout_q;
  assign HIT       = hit_q;

  // The low NBITS of the 2*NBITS product equal the NBITS-wide product, so no wide
  // intermediate is kept.
  assign prod = A * B;

  // if/else chain encodes the collision priority INC > ADD > SUB > ACC > CLR.
  always_comb begin
    xout_d = prod;
    hit_d  = 1'b1;
    acc_d  = acc_q;
    if (SEL == SelInc) begin
      xout_d = A + NBITS'(1);
    end else if (SEL == SelAdd) begin
      xout_d = A + B;
    end else if (SEL == SelSub) begin
      xout_d = A - B;
    end else if (SEL == SelAcc) begin
      acc_d  = acc_q + prod;
      xout_d = acc_d;
    end else if (SEL == SelClr) begin
      xout_d = acc_q;
      acc_d  = '0;
    end else begin
      hit_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      xout_q      <= '0;
      hit_q       <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      xout_q      <= xout_d;
      hit_q       <= hit_d;
    end else if (transfer) begin
      out_valid_q <= 1'b0;
    end
  end

  // acc_d equals acc_q for non-accumulator selectors, so gating on accept suffices.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= acc_d;
    end
  end

endmodule
